// File: rtl/enhance_axis_packer.sv
// Packs the 8-bit enhance pixel stream into 32-bit AXI4-Stream words with frame/line flags and an elastic FWFT FIFO.
// Optional feature macro: ENHANCE_BINARIZE_EN (threshold each pixel to 8'h00/8'hFF before packing).
module enhance_axis_packer #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                          s_axi_aclk,
    input  logic                          s_axi_aresetn,
    input  logic                          sensor_state,
    input  logic                          enhance_valid,
    input  logic [7:0]                    enhance_dout,
    input  logic [7:0]                    bin_thresh,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [31:0]                   m_axis_tdata,
    output logic                          m_axis_tuser,
    output logic                          m_axis_tlast,
    output logic                          overflow,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int HW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST   = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] COL_GRP0   = CW'(3);
    localparam logic [HW-1:0] LINE_LAST  = HW'(IMG_HEIGHT - 1);
    localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);

    logic [7:0]    pix_s;
    logic          accept_s;
    logic          push_s;
    logic          pop_s;
    logic          wr_en_s;
    logic          drop_s;
    logic          tuser_s;
    logic          tlast_s;
    logic [33:0]   entry_s;
    logic [33:0]   head_s;

    logic [1:0]    lane_r;
    logic [23:0]   pack_r;
    logic [CW-1:0] col_r;
    logic [HW-1:0] line_r;
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [LW-1:0] level_r;
    logic          overflow_r;
    logic          frame_done_r;
    logic [33:0]   mem_r [FIFO_DEPTH];

`ifdef ENHANCE_BINARIZE_EN
    // Threshold the incoming pixel to full black or full white.
    always_comb begin
        if (enhance_dout >= bin_thresh) begin
            pix_s = 8'hFF;
        end else begin
            pix_s = 8'h00;
        end
    end
`else
    logic unused_bin_thresh_s;
    assign unused_bin_thresh_s = ^bin_thresh;
    assign pix_s = enhance_dout;
`endif

    // Groups always start on a multiple of 4, so the group-start column is col_r-3 at the 4th pixel.
    assign accept_s = sensor_state & enhance_valid;
    assign push_s   = accept_s & (lane_r == 2'd3);
    assign pop_s    = (level_r != {LW{1'b0}}) & m_axis_tready;
    assign wr_en_s  = push_s & ((level_r != LEVEL_FULL) | pop_s);
    assign drop_s   = push_s & (level_r == LEVEL_FULL) & ~pop_s;
    assign tuser_s  = (line_r == {HW{1'b0}}) & (col_r == COL_GRP0);
    assign tlast_s  = (col_r == COL_LAST);
    assign entry_s  = {tuser_s, tlast_s, pix_s, pack_r};
    assign head_s   = mem_r[rd_ptr_r];

    // Outputs are forced to zero whenever the FIFO is empty so idle/reset state is deterministic.
    always_comb begin
        m_axis_tvalid = (level_r != {LW{1'b0}});
        m_axis_tdata  = 32'h0000_0000;
        m_axis_tuser  = 1'b0;
        m_axis_tlast  = 1'b0;
        if (m_axis_tvalid) begin
            m_axis_tdata = head_s[31:0];
            m_axis_tuser = head_s[33];
            m_axis_tlast = head_s[32];
        end else begin
            m_axis_tdata = 32'h0000_0000;
        end
    end

    assign overflow   = overflow_r;
    assign frame_done = frame_done_r;
    assign fifo_level = level_r;

    // FIFO storage; contents need no reset because the level gates visibility.
    always_ff @(posedge s_axi_aclk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= entry_s;
        end
    end

    // Packing, position counters, FIFO bookkeeping; sensor_state low acts as a synchronous flush.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            lane_r       <= 2'd0;
            pack_r       <= 24'h00_0000;
            col_r        <= {CW{1'b0}};
            line_r       <= {HW{1'b0}};
            wr_ptr_r     <= {AW{1'b0}};
            rd_ptr_r     <= {AW{1'b0}};
            level_r      <= {LW{1'b0}};
            overflow_r   <= 1'b0;
            frame_done_r <= 1'b0;
        end else if (!sensor_state) begin
            lane_r       <= 2'd0;
            pack_r       <= 24'h00_0000;
            col_r        <= {CW{1'b0}};
            line_r       <= {HW{1'b0}};
            wr_ptr_r     <= {AW{1'b0}};
            rd_ptr_r     <= {AW{1'b0}};
            level_r      <= {LW{1'b0}};
            overflow_r   <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= accept_s & (col_r == COL_LAST) & (line_r == LINE_LAST);
            if (accept_s) begin
                lane_r <= lane_r + 2'd1;
                case (lane_r)
                    2'd0:    pack_r[7:0]   <= pix_s;
                    2'd1:    pack_r[15:8]  <= pix_s;
                    2'd2:    pack_r[23:16] <= pix_s;
                    default: pack_r        <= 24'h00_0000;
                endcase
                // Counters advance regardless of drops so framing survives overflow.
                if (col_r == COL_LAST) begin
                    col_r <= {CW{1'b0}};
                    if (line_r == LINE_LAST) begin
                        line_r <= {HW{1'b0}};
                    end else begin
                        line_r <= line_r + HW'(1);
                    end
                end else begin
                    col_r <= col_r + CW'(1);
                end
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({wr_en_s, pop_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

endmodule
